// File: rtl/adc_capture_buffer.sv
// ADC capture buffer: arms on start_i, fills a 2**Width-entry RAM with strobed samples, then holds it for readout.
// Optional build macro CAPTURE_DECIM_EN enables 2:1 decimation of the sample strobe during capture.
module adc_capture_buffer #(
  parameter int Width = 5,
  parameter int DataW = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DataW-1:0] sample_i,
  input  logic             sample_valid_i,
  input  logic [Width-1:0] rd_addr_i,
  output logic [DataW-1:0] rd_data_o,
  output logic [Width-1:0] wr_addr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] wr_addr_q, wr_addr_d;
  logic             overflow_q, overflow_d;
  logic             wr_en;
  logic             mem_we;
  logic [DataW-1:0] mem [0:(1<<Width)-1];

`ifdef CAPTURE_DECIM_EN
  logic phase_q, phase_d;
`endif

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
`ifdef CAPTURE_DECIM_EN
    phase_d    = phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = CAPTURE;
          wr_addr_d = '0;
`ifdef CAPTURE_DECIM_EN
          phase_d   = 1'b0;
`endif
        end
      end
      CAPTURE: begin
        // start_i is deliberately not decoded here: a capture runs to completion.
        if (sample_valid_i) begin
`ifdef CAPTURE_DECIM_EN
          phase_d = ~phase_q;
          wr_en   = ~phase_q;
`else
          wr_en   = 1'b1;
`endif
        end
        if (wr_en) begin
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == '1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // A restart wins over a coincident strobe; that strobe is neither written nor an overflow.
        if (start_i) begin
          state_d    = CAPTURE;
          wr_addr_d  = '0;
          overflow_d = 1'b0;
`ifdef CAPTURE_DECIM_EN
          phase_d    = 1'b0;
`endif
        end else if (sample_valid_i) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      overflow_q <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
`ifdef CAPTURE_DECIM_EN
      phase_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      overflow_q <= overflow_d;
      busy_o     <= (state_q == CAPTURE);
      done_o     <= (state_q == DONE);
`ifdef CAPTURE_DECIM_EN
      phase_q    <= phase_d;
`endif
    end
  end

  // RAM port: contents never reset; a reset edge suppresses the write.
  assign mem_we = wr_en & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wr_addr_q] <= sample_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

  assign wr_addr_o  = wr_addr_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer (default build): vector table plus hand-written capture/readback sequences.
module tb_adc_capture_buffer;

  localparam int Width = 5;
  localparam int DataW = 12;

  logic             clk;
  logic             rst;
  logic             start;
  logic [DataW-1:0] sample;
  logic             sample_valid;
  logic [Width-1:0] rd_addr;
  logic [DataW-1:0] rd_data;
  logic [Width-1:0] wr_addr;
  logic             busy;
  logic             done;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  adc_capture_buffer #(.Width(Width), .DataW(DataW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .sample_i      (sample),
    .sample_valid_i(sample_valid),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .wr_addr_o     (wr_addr),
    .busy_o        (busy),
    .done_o        (done),
    .overflow_o    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             rst;
    logic             start;
    logic             valid;
    logic [DataW-1:0] sample;
    logic [Width-1:0] rd_addr;
    logic             exp_busy;
    logic             exp_done;
    logic [Width-1:0] exp_wr;
    logic             exp_ovf;
    logic             chk_rd;
    logic [DataW-1:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mkv(string name, logic r, logic s, logic v, int smp, int ra,
                               logic eb, logic ed, int ew, logic eo, logic cr, int erd);
    vec_t t;
    t.name     = name;
    t.rst      = r;
    t.start    = s;
    t.valid    = v;
    t.sample   = DataW'(smp);
    t.rd_addr  = Width'(ra);
    t.exp_busy = eb;
    t.exp_done = ed;
    t.exp_wr   = Width'(ew);
    t.exp_ovf  = eo;
    t.chk_rd   = cr;
    t.exp_rd   = DataW'(erd);
    return t;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input int smp, input int ra);
    rst          = r;
    start        = s;
    sample_valid = v;
    sample       = DataW'(smp);
    rd_addr      = Width'(ra);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i);
    drive(vecs[i].rst, vecs[i].start, vecs[i].valid, int'(vecs[i].sample), int'(vecs[i].rd_addr));
    step();
    check({vecs[i].name, ".busy"},     int'(busy),     int'(vecs[i].exp_busy));
    check({vecs[i].name, ".done"},     int'(done),     int'(vecs[i].exp_done));
    check({vecs[i].name, ".wr_addr"},  int'(wr_addr),  int'(vecs[i].exp_wr));
    check({vecs[i].name, ".overflow"}, int'(overflow), int'(vecs[i].exp_ovf));
    if (vecs[i].chk_rd) begin
      check({vecs[i].name, ".rd_data"}, int'(rd_data), int'(vecs[i].exp_rd));
    end
  endtask

  initial begin
    //                 name                rst st vl sample ra   busy done wr ovf chk rd
    vecs[0]  = mkv("reset",             1, 0, 0, 0,     0,   0,   0,   0, 0,  1,  0);
    vecs[1]  = mkv("idle_sample",       0, 0, 1, 5,     0,   0,   0,   0, 0,  0,  0);
    vecs[2]  = mkv("start_with_sample", 0, 1, 1, 7,     0,   0,   0,   0, 0,  0,  0);
    vecs[3]  = mkv("capture_entry",     0, 0, 0, 0,     0,   1,   0,   0, 0,  0,  0);
    vecs[4]  = mkv("ovf_strobe1",       0, 0, 1, 4095,  0,   0,   1,   0, 1,  1,  100);
    vecs[5]  = mkv("ovf_strobe2",       0, 0, 1, 4095,  0,   0,   1,   0, 1,  1,  100);
    vecs[6]  = mkv("ovf_strobe3",       0, 0, 1, 4095,  0,   0,   1,   0, 1,  1,  100);
    vecs[7]  = mkv("restart",           0, 1, 1, 4095,  0,   0,   1,   0, 0,  1,  100);
    vecs[8]  = mkv("restart_busy",      0, 0, 0, 0,     0,   1,   0,   0, 0,  1,  100);
    vecs[9]  = mkv("rdw_same_addr",     0, 0, 1, 555,   0,   1,   0,   1, 0,  1,  100);
    vecs[10] = mkv("rdw_new_word",      0, 0, 0, 0,     0,   1,   0,   1, 0,  1,  555);

    drive(1'b1, 1'b0, 1'b0, 0, 0);
    step();

    for (int i = 0; i < 4; i++) apply_vec(i);

    // Full capture of 100+n; a start pulse offered at wr_addr 7 must be ignored.
    for (int n = 0; n < 32; n++) begin
      drive(1'b0, (n == 7), 1'b1, 100 + n, 0);
      step();
      check($sformatf("capture%0d.wr_addr", n), int'(wr_addr), (n + 1) % 32);
      check($sformatf("capture%0d.busy", n), int'(busy), 1);
      check($sformatf("capture%0d.done", n), int'(done), 0);
    end
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    step();
    check("full.busy", int'(busy), 0);
    check("full.done", int'(done), 1);
    check("full.wr_addr", int'(wr_addr), 0);
    check("full.overflow", int'(overflow), 0);

    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 1'b0, 1'b0, 0, k);
      step();
      check($sformatf("readback%0d", k), int'(rd_data), 100 + k);
    end

    for (int i = 4; i < 11; i++) apply_vec(i);

    for (int n = 1; n < 10; n++) begin
      drive(1'b0, 1'b0, 1'b1, 200 + n, 0);
      step();
      check($sformatf("second%0d.wr_addr", n), int'(wr_addr), n + 1);
    end

    // Reset mid-capture with a coincident strobe: nothing may land at address 10.
    drive(1'b1, 1'b0, 1'b1, 999, 0);
    step();
    check("midrst.wr_addr", int'(wr_addr), 0);
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.overflow", int'(overflow), 0);
    check("midrst.rd_data", int'(rd_data), 0);

    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b0, 1'b1, 888, 0);
      step();
      check($sformatf("postrst%0d.wr_addr", n), int'(wr_addr), 0);
      check($sformatf("postrst%0d.busy", n), int'(busy), 0);
    end

    drive(1'b0, 1'b0, 1'b0, 0, 10);
    step();
    check("mem10_kept", int'(rd_data), 110);
    drive(1'b0, 1'b0, 1'b0, 0, 5);
    step();
    check("mem5_second", int'(rd_data), 205);
    drive(1'b0, 1'b0, 1'b0, 0, 9);
    step();
    check("mem9_second", int'(rd_data), 209);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    step();
    check("mem0_second", int'(rd_data), 555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
